// File: rtl/count_display.sv
`default_nettype none
// ============================================================================
//  Module   : count_display
//  Brief    : Brings an asynchronous 4-bit event count into the clk domain
//             through a two-flop synchroniser with a stability filter, pulses
//             'changed' on every accepted value and drives a two-digit,
//             time-multiplexed seven-segment display (units / gap / tens / gap).
//  Config   : LEAD_ZERO_BLANK_EN - when defined, the tens digit is blanked
//             (segments off, slot timing kept) for values below 10.
//  Revision : 1.0 - initial release
// ============================================================================
module count_display #(
   parameter int SCAN_DIV = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] count_in,
   output logic [3:0] value,
   output logic       changed,
   output logic [6:0] seg,
   output logic [1:0] an
);

   localparam int                  c_CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(SCAN_DIV - 1);

   typedef enum logic [1:0] {
      ST_UNITS = 2'd0,
      ST_GAP0  = 2'd1,
      ST_TENS  = 2'd2,
      ST_GAP1  = 2'd3
   } state_t;

   logic [3:0]         r_s1;
   logic [3:0]         r_s2;
   logic [3:0]         r_value;
   logic               r_changed;
   state_t             r_state;
   logic [c_CNT_W-1:0] r_cnt;
   logic               r_run;
   logic [1:0]         r_an;
   logic [6:0]         r_seg;

   logic               w_tens;
   logic [3:0]         w_units;
   logic [6:0]         w_seg_units;
   logic [6:0]         w_seg_tens;

   // Active-high segment pattern for one decimal digit (a = bit 0).
   function automatic logic [6:0] f_dec(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'h3F;
         4'd1:    p = 7'h06;
         4'd2:    p = 7'h5B;
         4'd3:    p = 7'h4F;
         4'd4:    p = 7'h66;
         4'd5:    p = 7'h6D;
         4'd6:    p = 7'h7D;
         4'd7:    p = 7'h07;
         4'd8:    p = 7'h7F;
         4'd9:    p = 7'h6F;
         default: p = 7'h00;
      endcase
      return p;
   endfunction

   // Two-flop synchroniser for the asynchronous count bus.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1 <= 4'd0;
         r_s2 <= 4'd0;
      end else begin
         r_s1 <= count_in;
         r_s2 <= r_s1;
      end
   end

   // Stability filter: the history stage s3 would hold s2 of the previous
   // edge, so at this edge the new s2/s3 pair is exactly r_s1/r_s2. Comparing
   // those directly accepts a value on the same edge s3 would capture it and
   // rejects any sample that did not persist for two consecutive edges.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_value   <= 4'd0;
         r_changed <= 1'b0;
      end else if ((r_s1 == r_s2) && (r_s1 != r_value)) begin
         r_value   <= r_s1;
         r_changed <= 1'b1;
      end else begin
         r_changed <= 1'b0;
      end
   end

   // BCD split of 0..15 and per-digit segment patterns.
   always_comb begin
      w_tens      = (r_value >= 4'd10);
      w_units     = w_tens ? (r_value - 4'd10) : r_value;
      w_seg_units = f_dec(w_units);
`ifdef LEAD_ZERO_BLANK_EN
      w_seg_tens  = w_tens ? 7'h06 : 7'h00;
`else
      w_seg_tens  = w_tens ? 7'h06 : 7'h3F;
`endif
   end

   // Scan FSM; an/seg are registered with the values of the state entered.
   // r_run holds scan_cnt at 0 on the first edge after reset so the opening
   // UNITS slot is lit for the full SCAN_DIV cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_UNITS;
         r_cnt   <= '0;
         r_run   <= 1'b0;
         r_an    <= 2'b00;
         r_seg   <= 7'h00;
      end else begin
         r_run <= 1'b1;
         case (r_state)
            ST_UNITS: begin
               if (r_run && (r_cnt == c_LAST)) begin
                  r_state <= ST_GAP0;
                  r_cnt   <= '0;
                  r_an    <= 2'b00;
                  r_seg   <= 7'h00;
               end else begin
                  if (r_run) begin
                     r_cnt <= r_cnt + 1'b1;
                  end
                  r_an  <= 2'b01;
                  r_seg <= w_seg_units;
               end
            end
            ST_GAP0: begin
               r_state <= ST_TENS;
               r_cnt   <= '0;
               r_an    <= 2'b10;
               r_seg   <= w_seg_tens;
            end
            ST_TENS: begin
               if (r_cnt == c_LAST) begin
                  r_state <= ST_GAP1;
                  r_cnt   <= '0;
                  r_an    <= 2'b00;
                  r_seg   <= 7'h00;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  r_an  <= 2'b10;
                  r_seg <= w_seg_tens;
               end
            end
            default: begin
               r_state <= ST_UNITS;
               r_cnt   <= '0;
               r_an    <= 2'b01;
               r_seg   <= w_seg_units;
            end
         endcase
      end
   end

   assign value   = r_value;
   assign changed = r_changed;
   assign seg     = r_seg;
   assign an      = r_an;

endmodule
`default_nettype wire

// File: doc/count_display.md
# count_display

Downstream consumer of the 4-bit ripple-clocked event counter. Brings the counter's `count` value into the system `clk` domain with a synchroniser and stability filter, and flags each accepted change. Renders the value 0–15 as two decimal digits on a time-multiplexed, two-digit seven-segment display, inserting blanking gaps between digits.

## Interface
Parameters:
- `SCAN_DIV`, default 16: `clk` cycles each digit is lit per scan; must be ≥ 2; scan counter width is `$clog2(SCAN_DIV)`.

Ports:
- `clk` in 1: system clock; all state is on the rising edge.
- `rst` in 1: asynchronous, active-low reset; clears all state immediately.
- `count_in` in 4: counter value; generated on a divided clock, so treated as asynchronous to `clk`.
- `value` out 4: filtered, accepted count; reset 0.
- `changed` out 1: one-cycle pulse when `value` updates; reset 0.
- `seg` out 7: segments, active-high, `seg[0]`=a … `seg[6]`=g; registered; reset 7'h00.
- `an` out 2: digit enables, one-hot or zero, active-high, `an[0]`=units, `an[1]`=tens; registered; reset 2'b00.

## Operation
- **Synchroniser:** two flops per bit (`s1`, `s2`), then a history register `s3` <= `s2`.
- **Acceptance:** when `s2 == s3` and `s2 != value`:
  - `value` <= `s2`;
  - `changed` <= 1;
  - otherwise `changed` <= 0.
  - This rejects bit-skewed samples.
- **BCD split:**
  - tens = (`value` ≥ 10);
  - units = `value` − 10 when tens is 1, else `value`;
  - all arithmetic is 4-bit, with no overflow possible.
- **Decode (hex):** 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F; tens digit 1 uses 06.
- **Scan FSM:** states UNITS → GAP0 → TENS → GAP1 → UNITS.
  - UNITS and TENS each last `SCAN_DIV` cycles, timed by `scan_cnt` 0..`SCAN_DIV`−1; the state advances when `scan_cnt` reaches `SCAN_DIV`−1, and `scan_cnt` then returns to 0.
  - GAP0 and GAP1 last exactly 1 cycle; `scan_cnt` is held at 0.
  - Reset state: UNITS, `scan_cnt`=0.
- **Output registers (next-state values):**
  - UNITS: `an`=01, `seg`=decode(units).
  - TENS: `an`=10, `seg`=decode(tens).
  - GAP0/GAP1: `an`=00, `seg`=00.
- If `value` changes while a digit is lit, `seg` shows the new pattern from the next edge, within the same slot. There is no slot restart.

## Timing
- **`count_in` to `value`:** if `count_in` settles before edge N, then `s2` is valid after N+1 and `value` and `changed` update at edge N+2. That is a 3-edge worst case, counting the edge N sample.
- **`changed`:** exactly one cycle per accepted value. Back-to-back changes each produce a pulse. A value that reverts to the same number before acceptance produces no pulse.
- **`value` to display:** `seg` reflects a new `value` one edge later, provided the relevant digit slot is active.
- **Scan period:** 2·`SCAN_DIV`+2 cycles. The units digit is lit for `SCAN_DIV` cycles per period.
- **After reset release:**
  - first edge: `an`=01, `seg`=3F (units 0);
  - the UNITS slot then runs its full `SCAN_DIV` cycles from that edge.
- **Mid-operation reset assertion:** `an`, `seg`, `value`, `changed`, the synchroniser, `scan_cnt` and the FSM clear asynchronously, with no wait for `clk`.
- **Wrap:** `count_in` 15→0 is an ordinary change. `value` becomes 0 and `changed` pulses.

## Configuration
- **Macro `LEAD_ZERO_BLANK_EN`, defined:** when `value` < 10, the TENS slot drives `an`=10 with `seg`=00. The slot timing is unchanged, so brightness stays uniform.
- **Undefined:** the TENS slot always shows its digit, so `value` < 10 displays a leading 0 (3F).

## Test plan
- **Reset:**
  - hold `rst`=0 with `count_in`=9 → `an`=00, `seg`=00, `value`=0, `changed`=0;
  - release → `value`=9 and `changed` pulses one cycle within 3 edges.
- **Scan with `SCAN_DIV`=4, `count_in`=12 steady:**
  - `an` sequence is 01×4, 00×1, 10×4, 00×1, repeating;
  - `seg` is 5B in units slots and 06 in tens slots.
- **Skew filter:** drive `count_in` 7→8 with a 1-cycle intermediate 15 glitch → `value` goes directly to 8, with one `changed` pulse and never 15.
- **Wrap:** step `count_in` 14, 15, 0, holding each for 8 cycles → three `changed` pulses; `value` becomes 0; the units slot shows 3F.
- **Macro:** `count_in`=5 with `LEAD_ZERO_BLANK_EN` → the TENS slot shows `an`=10, `seg`=00. Without the macro → the TENS slot shows `seg`=3F.
- **Async reset mid-scan:** assert `rst` during the TENS slot, between edges → `an`=00 and `seg`=00 immediately; after release, the display restarts in UNITS.
